// File: rtl/load_queue_pkg.sv
// Shared sizes, per-entry state encoding and entry record for the load queue.
package load_queue_pkg;
    localparam int LQ_SZ    = 8;
    localparam int SQ_SZ    = 8;
    localparam int XLEN     = 32;
    localparam int TAG_W    = 6;
    localparam int LQ_IDX_W = $clog2(LQ_SZ);
    localparam int SQ_IDX_W = $clog2(SQ_SZ);
    localparam int CNT_W    = LQ_IDX_W + 1;

    typedef enum logic [2:0] {
        LQ_EMPTY,
        LQ_WAIT_ADDR,
        LQ_READY,
        LQ_MEM_WAIT,
        LQ_DATA,
        LQ_WB_DONE
    } lq_state_e;

    typedef struct packed {
        lq_state_e             state;
        logic [TAG_W-1:0]      tag;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       data;
        logic [SQ_IDX_W-1:0]   sq_age;
    } lq_entry_t;
endpackage

// File: rtl/load_queue_picker.sv
// Head-rotated priority select: returns the oldest entry whose match bit is set.
module load_queue_picker #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] head,
    input  logic [N-1:0]     match,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    logic [IDX_W-1:0] j;

    // Walk youngest-to-oldest so the last hit written is the oldest one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = head + IDX_W'(i);
            if (match[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/load_queue.sv
// In-order load queue: SQ forwarding search, single-outstanding dcache miss path, CDB writeback.
module load_queue
    import load_queue_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_en,
    input  logic [TAG_W-1:0]    alloc_tag,
    input  logic [SQ_IDX_W-1:0] alloc_sq_tail,
    output logic [LQ_IDX_W-1:0] alloc_idx,
    output logic                lq_full,
    input  logic                addr_en,
    input  logic [LQ_IDX_W-1:0] addr_idx,
    input  logic [XLEN-1:0]     addr,
    output logic                sq_srch_valid,
    output logic [XLEN-1:0]     sq_srch_addr,
    output logic [SQ_IDX_W-1:0] sq_srch_age,
    input  logic                sq_srch_hit,
    input  logic [XLEN-1:0]     sq_srch_data,
    input  logic                sq_srch_unk,
    output logic                dc_req_valid,
    output logic [XLEN-1:0]     dc_req_addr,
    input  logic                dc_req_ready,
    input  logic                dc_rsp_valid,
    input  logic [XLEN-1:0]     dc_rsp_data,
    output logic                wb_valid,
    output logic [TAG_W-1:0]    wb_tag,
    output logic [XLEN-1:0]     wb_data,
    input  logic                wb_ready,
    input  logic                retire_en,
    input  logic                squash
);
    lq_entry_t           entries [LQ_SZ];
    logic [LQ_IDX_W-1:0] head, tail, pend_idx;
    logic [CNT_W-1:0]    count;
    logic                mem_busy, drop_rsp;

    logic [LQ_SZ-1:0]    ready_vec, data_vec;
    logic [LQ_IDX_W-1:0] s_idx, w_idx;
    logic                s_valid, w_valid;
    logic                alloc_fire, retire_fire, dc_fire;

    always_comb begin
        ready_vec = '0;
        data_vec  = '0;
        for (int k = 0; k < LQ_SZ; k++) begin
            ready_vec[k] = (entries[k].state == LQ_READY);
            data_vec[k]  = (entries[k].state == LQ_DATA);
        end
    end

    load_queue_picker #(.N(LQ_SZ), .IDX_W(LQ_IDX_W)) u_srch_pick (
        .head(head), .match(ready_vec), .idx(s_idx), .valid(s_valid)
    );

    load_queue_picker #(.N(LQ_SZ), .IDX_W(LQ_IDX_W)) u_wb_pick (
        .head(head), .match(data_vec), .idx(w_idx), .valid(w_valid)
    );

    assign lq_full     = (count == CNT_W'(LQ_SZ));
    assign alloc_idx   = tail;
    assign alloc_fire  = alloc_en && !lq_full;
    assign retire_fire = retire_en && (entries[head].state == LQ_WB_DONE);

    assign sq_srch_valid = s_valid;
    assign sq_srch_addr  = s_valid ? entries[s_idx].addr : '0;
    assign sq_srch_age   = s_valid ? entries[s_idx].sq_age : '0;

    // A squashed-but-unreturned response still occupies the dcache, so block new issue.
    assign dc_req_valid = s_valid && !sq_srch_hit && !sq_srch_unk && !mem_busy
                          && !drop_rsp && !squash;
    assign dc_req_addr  = dc_req_valid ? entries[s_idx].addr : '0;
    assign dc_fire      = dc_req_valid && dc_req_ready;

    assign wb_valid = w_valid;
    assign wb_tag   = w_valid ? entries[w_idx].tag : '0;
    assign wb_data  = w_valid ? entries[w_idx].data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LQ_SZ; k++) entries[k] <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pend_idx <= '0;
            mem_busy <= 1'b0;
            drop_rsp <= 1'b0;
        end else if (squash) begin
            for (int k = 0; k < LQ_SZ; k++) entries[k].state <= LQ_EMPTY;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_busy <= 1'b0;
            drop_rsp <= (mem_busy || drop_rsp) && !dc_rsp_valid;
        end else begin
            // Each event below targets an entry in a distinct state, so they never collide.
            if (alloc_fire) begin
                entries[tail].state  <= LQ_WAIT_ADDR;
                entries[tail].tag    <= alloc_tag;
                entries[tail].addr   <= '0;
                entries[tail].data   <= '0;
                entries[tail].sq_age <= alloc_sq_tail;
                tail <= tail + 1'b1;
            end
            if (addr_en && entries[addr_idx].state == LQ_WAIT_ADDR) begin
                entries[addr_idx].state <= LQ_READY;
                entries[addr_idx].addr  <= addr;
            end
            if (s_valid && sq_srch_hit) begin
                entries[s_idx].state <= LQ_DATA;
                entries[s_idx].data  <= sq_srch_data;
            end else if (dc_fire) begin
                entries[s_idx].state <= LQ_MEM_WAIT;
                mem_busy <= 1'b1;
                pend_idx <= s_idx;
            end
            if (dc_rsp_valid) begin
                if (drop_rsp) begin
                    drop_rsp <= 1'b0;
                end else if (mem_busy) begin
                    entries[pend_idx].state <= LQ_DATA;
                    entries[pend_idx].data  <= dc_rsp_data;
                    mem_busy <= 1'b0;
                end
            end
            if (w_valid && wb_ready) entries[w_idx].state <= LQ_WB_DONE;
            if (retire_fire) begin
                entries[head].state <= LQ_EMPTY;
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
        end
    end
endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: forwarding, dcache miss, full/wrap, unknown-store stall, squash drop.
module tb_load_queue;
    import load_queue_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic                alloc_en;
    logic [TAG_W-1:0]    alloc_tag;
    logic [SQ_IDX_W-1:0] alloc_sq_tail;
    logic [LQ_IDX_W-1:0] alloc_idx;
    logic                lq_full;
    logic                addr_en;
    logic [LQ_IDX_W-1:0] addr_idx;
    logic [XLEN-1:0]     addr;
    logic                sq_srch_valid;
    logic [XLEN-1:0]     sq_srch_addr;
    logic [SQ_IDX_W-1:0] sq_srch_age;
    logic                sq_srch_hit;
    logic [XLEN-1:0]     sq_srch_data;
    logic                sq_srch_unk;
    logic                dc_req_valid;
    logic [XLEN-1:0]     dc_req_addr;
    logic                dc_req_ready;
    logic                dc_rsp_valid;
    logic [XLEN-1:0]     dc_rsp_data;
    logic                wb_valid;
    logic [TAG_W-1:0]    wb_tag;
    logic [XLEN-1:0]     wb_data;
    logic                wb_ready;
    logic                retire_en;
    logic                squash;

    int vectors = 0;
    int miscompares = 0;

    load_queue dut (
        .clock(clock), .reset(reset),
        .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_sq_tail(alloc_sq_tail),
        .alloc_idx(alloc_idx), .lq_full(lq_full),
        .addr_en(addr_en), .addr_idx(addr_idx), .addr(addr),
        .sq_srch_valid(sq_srch_valid), .sq_srch_addr(sq_srch_addr), .sq_srch_age(sq_srch_age),
        .sq_srch_hit(sq_srch_hit), .sq_srch_data(sq_srch_data), .sq_srch_unk(sq_srch_unk),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready),
        .retire_en(retire_en), .squash(squash)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run after a further 1ns settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        alloc_en = 0; alloc_tag = '0; alloc_sq_tail = '0;
        addr_en = 0; addr_idx = '0; addr = '0;
        sq_srch_hit = 0; sq_srch_data = '0; sq_srch_unk = 0;
        dc_req_ready = 0; dc_rsp_valid = 0; dc_rsp_data = '0;
        wb_ready = 0; retire_en = 0; squash = 0;
        #12;
        chk("rst_full", 32'(lq_full), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_srch_valid", 32'(sq_srch_valid), 0);
        chk("rst_dc_req", 32'(dc_req_valid), 0);
        chk("rst_alloc_idx", 32'(alloc_idx), 0);
        reset = 1'b1;
        tick();

        // Store-forward hit
        alloc_en = 1; alloc_tag = 5; alloc_sq_tail = 3;
        #1 chk("fw_alloc_idx", 32'(alloc_idx), 0);
        tick(); alloc_en = 0;
        addr_en = 1; addr_idx = 0; addr = 32'h100;
        tick(); addr_en = 0;
        #1 chk("fw_srch_valid", 32'(sq_srch_valid), 1);
        chk("fw_srch_addr", sq_srch_addr, 32'h100);
        chk("fw_srch_age", 32'(sq_srch_age), 3);
        sq_srch_hit = 1; sq_srch_data = 32'hDEAD;
        #1 chk("fw_no_dc_req", 32'(dc_req_valid), 0);
        tick(); sq_srch_hit = 0;
        #1 chk("fw_wb_valid", 32'(wb_valid), 1);
        chk("fw_wb_tag", 32'(wb_tag), 5);
        chk("fw_wb_data", wb_data, 32'hDEAD);
        wb_ready = 1;
        tick(); wb_ready = 0;
        #1 chk("fw_wb_done", 32'(wb_valid), 0);
        retire_en = 1;
        tick(); retire_en = 0;

        // Dcache miss path, plus retire attempt while head is still in DATA
        alloc_en = 1; alloc_tag = 7; alloc_sq_tail = 0;
        #1 chk("dc_alloc_idx", 32'(alloc_idx), 1);
        tick(); alloc_en = 0;
        addr_en = 1; addr_idx = 1; addr = 32'h100;
        tick(); addr_en = 0;
        dc_req_ready = 1;
        #1 chk("dc_req_valid", 32'(dc_req_valid), 1);
        chk("dc_req_addr", dc_req_addr, 32'h100);
        tick(); dc_req_ready = 0;
        #1 chk("dc_busy_no_req", 32'(dc_req_valid), 0);
        chk("dc_busy_no_srch", 32'(sq_srch_valid), 0);
        tick(); tick();
        dc_rsp_valid = 1; dc_rsp_data = 32'h1234;
        tick(); dc_rsp_valid = 0;
        #1 chk("dc_wb_valid", 32'(wb_valid), 1);
        chk("dc_wb_tag", 32'(wb_tag), 7);
        chk("dc_wb_data", wb_data, 32'h1234);
        retire_en = 1;
        tick(); retire_en = 0;
        #1 chk("ret_ign_wb_valid", 32'(wb_valid), 1);
        chk("ret_ign_wb_tag", 32'(wb_tag), 7);
        chk("ret_ign_tail", 32'(alloc_idx), 2);
        wb_ready = 1;
        tick(); wb_ready = 0;
        retire_en = 1;
        tick(); retire_en = 0;

        // Unresolved older store stalls, then forwards
        alloc_en = 1; alloc_tag = 9; alloc_sq_tail = 1;
        #1 chk("unk_alloc_idx", 32'(alloc_idx), 2);
        tick(); alloc_en = 0;
        addr_en = 1; addr_idx = 2; addr = 32'h200;
        tick(); addr_en = 0;
        sq_srch_unk = 1; dc_req_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("unk_no_dc_req", 32'(dc_req_valid), 0);
            chk("unk_srch_addr", sq_srch_addr, 32'h200);
            tick();
        end
        sq_srch_unk = 0; sq_srch_hit = 1; sq_srch_data = 32'hBEEF;
        #1 chk("unk_clear_no_req", 32'(dc_req_valid), 0);
        tick(); sq_srch_hit = 0; dc_req_ready = 0;
        #1 chk("unk_wb_tag", 32'(wb_tag), 9);
        chk("unk_wb_data", wb_data, 32'hBEEF);
        wb_ready = 1;
        tick(); wb_ready = 0;
        retire_en = 1;
        tick(); retire_en = 0;

        // Squash with a dcache request in flight; late response must be dropped
        alloc_en = 1; alloc_tag = 11;
        #1 chk("sq_alloc_idx", 32'(alloc_idx), 3);
        tick(); alloc_en = 0;
        addr_en = 1; addr_idx = 3; addr = 32'h300;
        tick(); addr_en = 0;
        dc_req_ready = 1;
        #1 chk("sq_dc_req", 32'(dc_req_valid), 1);
        tick(); dc_req_ready = 0;
        squash = 1;
        tick(); squash = 0;
        tick();
        dc_rsp_valid = 1; dc_rsp_data = 32'h5555;
        tick(); dc_rsp_valid = 0;
        #1 chk("sq_no_wb", 32'(wb_valid), 0);
        chk("sq_no_srch", 32'(sq_srch_valid), 0);
        chk("sq_tail_zero", 32'(alloc_idx), 0);
        chk("sq_not_full", 32'(lq_full), 0);
        tick();
        chk("sq_no_wb_late", 32'(wb_valid), 0);

        // Fill to full, drop a 9th alloc, then alloc+retire in the same cycle
        alloc_en = 1;
        for (int i = 0; i < LQ_SZ; i++) begin
            alloc_tag = TAG_W'(20 + i);
            #1 chk("fill_alloc_idx", 32'(alloc_idx), 32'(i));
            tick();
        end
        #1 chk("fill_full", 32'(lq_full), 1);
        chk("fill_tail_wrap", 32'(alloc_idx), 0);
        alloc_tag = 30;
        tick(); alloc_en = 0;
        #1 chk("drop9_full", 32'(lq_full), 1);
        chk("drop9_tail", 32'(alloc_idx), 0);
        for (int i = 0; i < 2; i++) begin
            addr_en = 1; addr_idx = LQ_IDX_W'(i); addr = 32'h400 + 32'(4 * i);
            tick(); addr_en = 0;
            sq_srch_hit = 1; sq_srch_data = 32'hA0 + 32'(i);
            tick(); sq_srch_hit = 0;
            #1 chk("fill_wb_tag", 32'(wb_tag), 32'(20 + i));
            wb_ready = 1;
            tick(); wb_ready = 0;
        end
        retire_en = 1;
        tick(); retire_en = 0;
        #1 chk("ret1_not_full", 32'(lq_full), 0);
        retire_en = 1; alloc_en = 1; alloc_tag = 40;
        #1 chk("both_alloc_idx", 32'(alloc_idx), 0);
        tick(); retire_en = 0;
        #1 chk("both_count_same", 32'(lq_full), 0);
        chk("both_tail", 32'(alloc_idx), 1);
        tick(); alloc_en = 0;
        #1 chk("refill_full", 32'(lq_full), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
